// File: rtl/matmul_tile_ctrl_pkg.sv
// Shared state type, default dimensions and packing helper for the matmul tile controller.
package matmul_tile_ctrl_pkg;

    localparam int DEF_N    = 4;
    localparam int DEF_W    = 8;
    localparam int DEF_ACCW = 32;
    localparam int DEF_AW   = 10;
    localparam int DEF_KW   = 8;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STREAM,
        OUT
    } state_t;

    // Bit offset of element idx inside a flat vector of width-bit elements.
    function automatic int elem_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// K-step counter with latched operand bases; produces the A/B read addresses for a job.
module matmul_addr_gen
    import matmul_tile_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int KW = DEF_KW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [KW-1:0] k_len,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] b_base,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          last
);

    logic [KW-1:0] k;
    logic [KW-1:0] k_len_q;
    logic [AW-1:0] a_base_q;
    logic [AW-1:0] b_base_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            k_len_q  <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
        end else if (load) begin
            k        <= '0;
            k_len_q  <= k_len;
            a_base_q <= a_base;
            b_base_q <= b_base;
        end else if (step) begin
            k <= k + 1'b1;
        end
    end

    // Addresses wrap modulo 2^AW by truncation of the sum.
    assign a_addr = a_base_q + AW'(k);
    assign b_addr = b_base_q + AW'(k);
    assign last   = (k == k_len_q);

endmodule

// File: rtl/matmul_tile_ctrl.sv
// Sequences one NxN output tile: clear the MAC array, stream K operand pairs, present the result.
module matmul_tile_ctrl
    import matmul_tile_ctrl_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int W    = DEF_W,
    parameter int ACCW = DEF_ACCW,
    parameter int AW   = DEF_AW,
    parameter int KW   = DEF_KW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    input  logic [AW-1:0]         a_base,
    input  logic [AW-1:0]         b_base,
    input  logic                  relu_en,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         a_addr,
    output logic [AW-1:0]         b_addr,
    input  logic [N*W-1:0]        a_rd_data,
    input  logic [N*W-1:0]        b_rd_data,
    output logic                  arr_clr,
    output logic                  arr_en,
    output logic [N*W-1:0]        arr_a,
    output logic [N*W-1:0]        arr_b,
    input  logic [N*N*ACCW-1:0]   arr_acc,
    output logic [N*N*ACCW-1:0]   res_data,
    output logic                  res_valid,
    input  logic                  res_ready
);

    state_t state;
    logic   relu_q;
    logic   load;
    logic   last;
    logic   issue;

    assign load = (state == IDLE) && start;

    // A read is issued in CLEAR and in every STREAM cycle until the counter reaches K.
    assign issue     = ((state == CLEAR) || (state == STREAM)) && !last;
    assign mem_rd_en = issue;

    matmul_addr_gen #(
        .AW (AW),
        .KW (KW)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (issue),
        .k_len  (k_len),
        .a_base (a_base),
        .b_base (b_base),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            arr_clr   <= 1'b0;
            arr_en    <= 1'b0;
            res_valid <= 1'b0;
            relu_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        arr_clr <= 1'b1;
                        relu_q  <= relu_en;
                    end
                end
                CLEAR: begin
                    arr_clr <= 1'b0;
                    if (last) begin
                        state     <= OUT;
                        res_valid <= 1'b1;
                    end else begin
                        state  <= STREAM;
                        arr_en <= 1'b1;
                    end
                end
                STREAM: begin
                    if (last) begin
                        state     <= OUT;
                        arr_en    <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign done  = res_valid && res_ready;
    assign arr_a = (state == STREAM) ? a_rd_data : '0;
    assign arr_b = (state == STREAM) ? b_rd_data : '0;

    // The array holds while in OUT, so gating with res_valid keeps the tile stable and zero otherwise.
    for (genvar e = 0; e < N*N; e++) begin : g_relu
        logic signed [ACCW-1:0] acc_e;
        assign acc_e = arr_acc[elem_lsb(e, ACCW) +: ACCW];
        assign res_data[elem_lsb(e, ACCW) +: ACCW] =
            (!res_valid || (relu_q && (acc_e < 0))) ? '0 : acc_e;
    end

endmodule

// File: doc/matmul_tile_ctrl.md
Name: matmul_tile_ctrl

Overview:
- Sequences one N×N output-tile matrix multiply on the NxN MAC array.
- Per job, it:
  - clears the array accumulators;
  - streams K column/row vector pairs from the A and B operand SRAMs;
  - presents the N×N result, optionally ReLU-rectified, on a valid/ready output.
- Array contract: each enabled cycle the array adds the outer product of a_in and b_in to its accumulators (acc[i][j] += a[i]*b[j]). Operands reach all MACs in the same cycle, so no input skew is applied.

Parameters:
- N, 4, array dimension.
- W, 8, signed operand width.
- ACCW, 32, signed accumulator width.
- AW, 10, operand SRAM address width.
- KW, 8, width of the K-depth field; maximum K is 2^KW-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  KW  inner dimension K; latched on start.
- a_base  in  AW  A-buffer base address; latched on start.
- b_base  in  AW  B-buffer base address; latched on start.
- relu_en  in  1  apply ReLU to the result; latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the result handshake.
- mem_rd_en  out  1  read strobe to both operand SRAMs.
- a_addr  out  AW  A read address; read data is returned 1 cycle later.
- b_addr  out  AW  B read address.
- a_rd_data  in  N*W  A column vector; element i in bits [i*W +: W].
- b_rd_data  in  N*W  B row vector; element j in bits [j*W +: W].
- arr_clr  out  1  array accumulator clear.
- arr_en  out  1  array accumulate enable.
- arr_a  out  N*W  array a_in.
- arr_b  out  N*W  array b_in.
- arr_acc  in  N*N*ACCW  array accumulators; element (i*N+j) in bits [(i*N+j)*ACCW +: ACCW].
- res_data  out  N*N*ACCW  result tile, same packing as arr_acc.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.

Behaviour:
- Reset values: state IDLE; busy, done, mem_rd_en, arr_clr, arr_en, res_valid = 0; addresses, arr_a, arr_b, res_data = 0; internal counter and latches = 0.
- Reset mid-job returns to IDLE the next cycle. The partial job is discarded and no done pulse is produced.
- IDLE:
  - start=1 latches k_len, a_base, b_base and relu_en, then goes to CLEAR.
  - Inputs are ignored when start=0.
- CLEAR (1 cycle):
  - arr_clr=1 and arr_en=0.
  - If K>0: mem_rd_en=1, a_addr=a_base, b_addr=b_base, k counter set to 1, next state STREAM.
  - If K=0: mem_rd_en=0, next state OUT, which yields an all-zero tile.
- STREAM (exactly K cycles):
  - arr_en=1; arr_a=a_rd_data and arr_b=b_rd_data combinationally. These are the data for the address issued the previous cycle.
  - While k<K: mem_rd_en=1, a_addr=a_base+k, b_addr=b_base+k, then k++. mem_rd_en=0 on the final STREAM cycle.
  - After the K-th enabled cycle, go to OUT.
- Address arithmetic is modulo 2^AW; base+k wraps silently.
- OUT:
  - arr_en=0, so the array holds its accumulators.
  - res_valid=1.
  - res_data: each element e = arr_acc element, or (e>0 ? e : 0) signed when relu_en is set.
  - res_data must be stable while res_valid=1 and res_ready=0.
  - On res_valid&&res_ready: done=1 for that cycle, then IDLE. res_valid drops the following cycle.
- start asserted in any non-IDLE state is ignored, not queued.
- Latency: start sampled at edge t0 → CLEAR in cycle t0+1 → STREAM cycles t0+2..t0+K+1 → res_valid first high in cycle t0+K+2. For K=0, res_valid is high in cycle t0+2.
- With res_ready tied high, back-to-back jobs issue at most one per K+3 cycles. start may be high in the same cycle done pulses, but it is sampled only in IDLE, i.e. the next cycle.
- Arithmetic: accumulators wrap modulo 2^ACCW; there is no saturation. ReLU is a signed compare, and zero maps to zero.
- arr_a and arr_b are 0 in every non-STREAM state.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, CLEAR, STREAM, OUT};
  - default N, W, ACCW, AW, KW constants;
  - a function for the packed-element slice offset.
- One sub-module: matmul_addr_gen. It contains the k counter, base latches and address adders, with inputs load, step, k_len, a_base, b_base and outputs a_addr, b_addr, last.
- The ReLU stage is a generate loop inside the top module.

Test Plan:
- K=1, A col=[1,2,3,4], B row=[1,1,1,1], relu_en=0 → res_data row i = [i+1]×4; res_valid in cycle t0+3; a_addr=a_base during CLEAR.
- K=4, A=identity, B=rows [1..16] → res_data equals B; mem_rd_en high for exactly 4 cycles; arr_en high for exactly 4 cycles.
- K=2, A col0=[-3,...], B row0=[5,...], then zeros, relu_en=1 → element(0,0) is 0 with relu_en=1 and -15 with relu_en=0; the clear between jobs is verified.
- K=3, res_ready held low 5 cycles → res_data stable and res_valid held; done pulses exactly once on the accept cycle; a start during the wait is ignored.
- K=0 → arr_clr pulse, no reads, all-zero tile at t0+2; a_base=0x3FF with K=2 gives a_addr sequence 0x3FF then 0x000.
- rst asserted mid-STREAM → next cycle IDLE, busy=0, res_valid=0, no done; a new job afterwards produces correct results.
